// File: rtl/inv_round_function.sv
// inv_round_function: iterative AES inverse cipher (InvCipher), one decryption round per clock.
// Round keys come from an external store addressed by key_idx, highest index first; the
// store answers in the same cycle, so key_idx is the only key-related state kept here.
module inv_round_function #(
  parameter int NR_MAX    = 14,
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [1:0]           mode,
  input  logic                 start,
  output logic                 in_ready,
  input  logic [127:0]         cipher_in,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         round_key,
  output logic [127:0]         plain_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int RND_W = $clog2(NR_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [1:0]       state_q, state_d;
  logic [127:0]     st_q, st_d;
  logic [127:0]     plain_q, plain_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;
  logic [127:0]     roundOut;

  function automatic logic [RND_W-1:0] nrDecode(input logic [1:0] m);
    logic [RND_W-1:0] nr;
    case (m)
      2'b01:   nr = RND_W'(12);
      2'b10:   nr = RND_W'(14);
      default: nr = RND_W'(10);
    endcase
    return nr;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  // Row r of the state is rotated right by r columns; byte index is 4*col+row.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8 * (4 * col + row) -: 8] = s[127 - 8 * (4 * (((col - row) + 4) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8 * i -: 8] = invSbox(s[127 - 8 * i -: 8]);
    end
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k as a sum of a, 2a, 4a, 8a in GF(2^8).
  function automatic logic [7:0] gmulConst(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] invMixColumn(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = gmulConst(a0, 4'he) ^ gmulConst(a1, 4'hb) ^ gmulConst(a2, 4'hd) ^ gmulConst(a3, 4'h9);
    b1 = gmulConst(a0, 4'h9) ^ gmulConst(a1, 4'he) ^ gmulConst(a2, 4'hb) ^ gmulConst(a3, 4'hd);
    b2 = gmulConst(a0, 4'hd) ^ gmulConst(a1, 4'h9) ^ gmulConst(a2, 4'he) ^ gmulConst(a3, 4'hb);
    b3 = gmulConst(a0, 4'hb) ^ gmulConst(a1, 4'hd) ^ gmulConst(a2, 4'h9) ^ gmulConst(a3, 4'he);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      r[127 - 32 * col -: 32] = invMixColumn(s[127 - 32 * col -: 32]);
    end
    return r;
  endfunction

  // One inverse round up to the key addition; InvMixColumns is applied only when rounds remain.
  always_comb begin
    roundOut = invSubBytes(invShiftRows(st_q)) ^ round_key;
  end

  // Key index: decoded round count from the live mode while idle, otherwise the round counter.
  always_comb begin
    if (state_q == S_IDLE) begin
      key_idx = KEY_IDX_W'(nrDecode(mode));
    end else begin
      key_idx = KEY_IDX_W'(rnd_q);
    end
  end

  // Next-state logic; flush overrides everything, including a start in the same cycle.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    plain_d = plain_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      plain_d = '0;
      rnd_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            st_d    = cipher_in ^ round_key;
            rnd_d   = nrDecode(mode) - RND_W'(1);
            state_d = S_ROUND;
          end
        end
        S_ROUND: begin
          if (rnd_q != '0) begin
            st_d  = invMixColumns(roundOut);
            rnd_d = rnd_q - RND_W'(1);
          end else begin
            plain_d = roundOut;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
      plain_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      plain_q <= plain_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = valid_q;
  assign plain_out = plain_q;

endmodule
